iomem_slot_ctrl: RTL and testbench
==================================

// Module: iomem_slot_ctrl
// PURPOSE
//   Sequences picosoc iomem transactions in window 0x03xx_xxxx onto up to NUM_SLOTS peripherals.
//   Slot select is addr[23:20]; only the selected slot sees valid.
//   A bus watchdog guarantees the CPU always receives ready: unmapped slots and stalled peripherals
//   complete with ERR_DATA, and each such event is logged in err_count/err_addr.
//   Sits between soc iomem port and the gpio/peripheral registers in the top level.
// PARAMETERS
//   NUM_SLOTS  4             peripheral slots, 1..16
//   TIMEOUT    255           max wait cycles in BUSY before forced completion, 1..65535
//   BASE       8'h03         addr[31:24] value decoded by this block
//   ERR_DATA   32'hDEADBEEF  rdata returned on error/timeout
// PORTS
//   clk        in   1              clock
//   resetn     in   1              reset, synchronous, active-low
//   m_valid    in   1              iomem_valid from soc
//   m_ready    out  1              iomem_ready to soc (registered)
//   m_wstrb    in   4              byte strobes, 0 = read
//   m_addr     in   32             iomem address
//   m_wdata    in   32             write data
//   m_rdata    out  32             read data (registered)
//   s_valid    out  NUM_SLOTS      one-hot slot request
//   s_wstrb    out  4              latched strobes, broadcast
//   s_addr     out  20             latched addr[19:0], broadcast
//   s_wdata    out  32             latched wdata, broadcast
//   s_ready    in   NUM_SLOTS      slot completion, 1-cycle pulse
//   s_rdata    in   32*NUM_SLOTS   slot k read data at [32k+31:32k], valid with s_ready[k]
//   err_count  out  8              error/timeout events, saturates at 255
//   err_addr   out  32             m_addr of most recent error
// BEHAVIOUR
//   Reset (resetn=0 at posedge): state=IDLE.
//   - m_ready=0, s_valid=0, m_rdata=0, err_count=0, err_addr=0, wait counter=0.
//   - Reset aborts any in-flight transaction with no ack.
//   FSM IDLE:
//   - Starts when m_valid && m_addr[31:24]==BASE.
//   - Latches slot=addr[23:20], wstrb, addr[19:0], wdata.
//   - slot<NUM_SLOTS: s_valid[slot]<=1, cnt<=0, go BUSY.
//   - slot>=NUM_SLOTS: m_rdata<=ERR_DATA, log error, go ACK.
//   - Other addresses are ignored; block stays IDLE and never drives m_ready.
//   FSM BUSY:
//   - s_valid[slot] held high. s_ready of non-selected slots is ignored.
//   - s_ready[slot]=1: m_rdata<=s_rdata[slot] (for writes too), s_valid<=0, go ACK.
//   - Else cnt<=cnt+1; when cnt==TIMEOUT-1: s_valid<=0, m_rdata<=ERR_DATA, log error, go ACK.
//   - s_ready in the same cycle as expiry: s_ready wins, no error.
//   - Timed-out writes are dropped silently.
//   FSM ACK:
//   - m_ready=1 for exactly one cycle, then IDLE. m_valid is ignored in ACK.
//   - m_ready is 0 in every state except ACK.
//   Log error: err_count<=err_count+1 unless 255; err_addr<=m_addr (full 32 bits).
//   Latency, valid to m_ready:
//   - 3 cycles with an immediate s_ready.
//   - 2 cycles for an unmapped slot.
//   - TIMEOUT+2 cycles on timeout.
//   Latched s_* outputs are stable for the whole of BUSY.
// TESTING
//   1. Read 0x0310_0004, slot1 s_ready+rdata 0x12345678 one cycle after s_valid
//      -> s_valid=0010, s_addr=0x00004, m_rdata=0x12345678, m_ready 4 clk after m_valid, one cycle.
//   2. Write 0x0300_0000, wstrb=0001, wdata=0xA5 to slot0
//      -> s_wstrb=0001, s_wdata=0xA5, one m_ready pulse, err_count stays 0.
//   3. Access 0x0350_0000 with NUM_SLOTS=4
//      -> no s_valid, m_rdata=0xDEADBEEF, err_count=1, err_addr=0x03500000.
//   4. Slot2 never ready, TIMEOUT=8
//      -> s_valid high 8 cycles then 0, m_rdata=0xDEADBEEF, m_ready pulse, err_count+1.
//      Repeat with s_ready exactly at expiry -> slot data returned, no error.
//   5. Access 0x0200_0000 -> no s_valid, m_ready stays 0. Then resetn low mid-BUSY
//      -> next cycle s_valid=0, m_ready=0, err_count=0, state IDLE.
//   6. 300 unmapped accesses -> err_count saturates at 255.

Source files
------------

// File: rtl/iomem_slot_ctrl.sv
// iomem window sequencer: decodes 0x03xx_xxxx onto NUM_SLOTS peripheral slots.
// A watchdog makes sure every decoded access gets m_ready. Each error or timeout is logged.
module iomem_slot_ctrl #(
    parameter int          NUM_SLOTS = 4,
    parameter int          TIMEOUT   = 255,
    parameter logic [7:0]  BASE      = 8'h03,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      m_valid,
    output logic                      m_ready,
    input  logic [3:0]                m_wstrb,
    input  logic [31:0]               m_addr,
    input  logic [31:0]               m_wdata,
    output logic [31:0]               m_rdata,
    output logic [NUM_SLOTS-1:0]      s_valid,
    output logic [3:0]                s_wstrb,
    output logic [19:0]               s_addr,
    output logic [31:0]               s_wdata,
    input  logic [NUM_SLOTS-1:0]      s_ready,
    input  logic [32*NUM_SLOTS-1:0]   s_rdata,
    output logic [7:0]                err_count,
    output logic [31:0]               err_addr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ACK
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_m_ready;
    logic [31:0]            r_m_rdata;
    logic [NUM_SLOTS-1:0]   r_s_valid;
    logic [3:0]             r_wstrb;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [15:0]            r_cnt;
    logic [7:0]             r_err_count;
    logic [31:0]            r_err_addr;

    logic                   w_start;
    logic                   w_mapped;
    logic                   w_done_ok;
    logic                   w_timeout;
    logic                   w_log_err;
    logic                   w_sel_ready;
    logic [31:0]            w_sel_rdata;
    logic [31:0]            w_err_addr;
    logic [NUM_SLOTS-1:0]   w_onehot;

    // Only the latched slot's handshake is looked at, so stray s_ready pulses are harmless.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (r_addr[23:20] == 4'(k)) begin
                w_sel_ready = s_ready[k];
                w_sel_rdata = s_rdata[32*k +: 32];
            end
        end
    end

    assign w_onehot   = NUM_SLOTS'(1) << m_addr[23:20];
    assign w_err_addr = (r_state == ST_IDLE) ? m_addr : r_addr;

    // NOTE: every signal gets a default before the case statement. Without that, a path that
    // skips an assignment would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_mapped     = 1'b0;
        w_done_ok    = 1'b0;
        w_timeout    = 1'b0;
        w_log_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m_valid && (m_addr[31:24] == BASE)) begin
                    w_start = 1'b1;
                    if ({1'b0, m_addr[23:20]} < 5'(NUM_SLOTS)) begin
                        w_mapped     = 1'b1;
                        w_state_next = ST_BUSY;
                    end else begin
                        w_log_err    = 1'b1;
                        w_state_next = ST_ACK;
                    end
                end
            end
            ST_BUSY: begin
                if (w_sel_ready) begin
                    w_done_ok    = 1'b1;
                    w_state_next = ST_ACK;
                end else if (r_cnt == 16'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_log_err    = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update
    // together at the clock edge, regardless of the order of the statements.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_m_ready   <= 1'b0;
            r_m_rdata   <= '0;
            r_s_valid   <= '0;
            r_wstrb     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_m_ready <= (w_state_next == ST_ACK);

            if (w_start) begin
                r_wstrb <= m_wstrb;
                r_addr  <= m_addr;
                r_wdata <= m_wdata;
                r_cnt   <= '0;
                if (w_mapped) r_s_valid <= w_onehot;
                else          r_m_rdata <= ERR_DATA;
            end

            if (w_done_ok) begin
                r_m_rdata <= w_sel_rdata;
                r_s_valid <= '0;
            end else if (w_timeout) begin
                r_m_rdata <= ERR_DATA;
                r_s_valid <= '0;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_log_err) begin
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                r_err_addr <= w_err_addr;
            end
        end
    end

    assign m_ready   = r_m_ready;
    assign m_rdata   = r_m_rdata;
    assign s_valid   = r_s_valid;
    assign s_wstrb   = r_wstrb;
    assign s_addr    = r_addr[19:0];
    assign s_wdata   = r_wdata;
    assign err_count = r_err_count;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_iomem_slot_ctrl.sv
// Scoreboard bench for iomem_slot_ctrl. The stimulus side queues the expected responses.
// A monitor compares them each time m_ready is seen.
module tb_iomem_slot_ctrl;

    localparam int          NS      = 4;
    localparam int          TO      = 8;
    localparam logic [31:0] ERR     = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              resetn;
    logic              m_valid;
    logic              m_ready;
    logic [3:0]        m_wstrb;
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic [NS-1:0]     s_valid;
    logic [3:0]        s_wstrb;
    logic [19:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [NS-1:0]     s_ready;
    logic [32*NS-1:0]  s_rdata;
    logic [7:0]        err_count;
    logic [31:0]       err_addr;

    iomem_slot_ctrl #(.NUM_SLOTS(NS), .TIMEOUT(TO), .BASE(8'h03), .ERR_DATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .err_count(err_count), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [7:0]  ecnt;
        logic [31:0] eaddr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  mdl_ecnt = 8'd0;
    logic [31:0] mdl_eaddr = 32'd0;
    logic        prev_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: this process alone pops the scoreboard.
    always @(negedge clk) begin
        if (resetn && m_ready) begin
            check("ready_single_cycle", 64'(prev_ready), 64'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("m_rdata", 64'(m_rdata), 64'(e.rdata));
                check("err_count", 64'(err_count), 64'(e.ecnt));
                check("err_addr", 64'(err_addr), 64'(e.eaddr));
                check("s_valid_in_ack", 64'(s_valid), 64'd0);
            end
        end
        prev_ready = m_ready;
    end

    // resp_delay is the number of BUSY cycles before s_ready; -1 means the peripheral never answers.
    // exp_cycles counts the cycle in which m_valid is first presented.
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                          input int resp_delay, input logic [31:0] slot_data,
                          input logic [NS-1:0] exp_sv, input logic [31:0] exp_rdata,
                          input bit exp_err, input int exp_cycles, input int exp_sv_cycles);
        int   slot;
        int   cyc;
        int   nv;
        bit   got;
        exp_t e;
        slot = int'(addr[23:20]);
        if (exp_err) begin
            if (mdl_ecnt != 8'hFF) mdl_ecnt = mdl_ecnt + 8'd1;
            mdl_eaddr = addr;
        end
        e.rdata = exp_rdata;
        e.ecnt  = mdl_ecnt;
        e.eaddr = mdl_eaddr;
        sb_q.push_back(e);

        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = addr;
        m_wstrb = wstrb;
        m_wdata = wdata;
        cyc = 0;
        nv  = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            s_ready = '0;
            if (cyc == 1) check("s_valid_onehot", 64'(s_valid), 64'(exp_sv));
            if (m_ready) begin
                got = 1'b1;
                check("latency", 64'(cyc + 1), 64'(exp_cycles));
                m_valid = 1'b0;
            end else if (slot < NS && s_valid[slot]) begin
                check("s_latched", {8'd0, s_addr, s_wstrb, s_wdata}, {8'd0, addr[19:0], wstrb, wdata});
                if (nv == resp_delay) begin
                    s_ready[slot] = 1'b1;
                    s_rdata[32*slot +: 32] = slot_data;
                end else begin
                    // A neighbouring slot pulsing s_ready must not complete the access.
                    s_ready[(slot + 1) % NS] = 1'b1;
                    s_rdata[32*((slot + 1) % NS) +: 32] = 32'h5555AAAA;
                end
                nv++;
            end
        end
        s_ready = '0;
        if (!got) begin
            check("ready_watchdog", 64'd0, 64'd1);
            m_valid = 1'b0;
            if (sb_q.size() != 0) void'(sb_q.pop_back());
        end
        check("s_valid_cycles", 64'(nv), 64'(exp_sv_cycles));
    endtask

    initial begin
        int seen_ready;
        int seen_sv;
        resetn  = 1'b0;
        m_valid = 1'b0;
        m_addr  = '0;
        m_wstrb = '0;
        m_wdata = '0;
        s_ready = '0;
        s_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_ready", 64'(m_ready), 64'd0);
        check("rst_s_valid", 64'(s_valid), 64'd0);
        check("rst_m_rdata", 64'(m_rdata), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_err_addr", 64'(err_addr), 64'd0);
        resetn = 1'b1;

        // 1: read slot 1, s_ready one cycle after s_valid
        do_txn(32'h0310_0004, 4'b0000, 32'h0, 1, 32'h1234_5678, 4'b0010, 32'h1234_5678, 1'b0, 4, 2);
        // immediate s_ready: 3-cycle latency
        do_txn(32'h0330_0010, 4'b0000, 32'h0, 0, 32'h0BEE_F001, 4'b1000, 32'h0BEE_F001, 1'b0, 3, 1);
        // 2: write slot 0; slot read data is still returned
        do_txn(32'h0300_0000, 4'b0001, 32'h0000_00A5, 0, 32'hCAFE_0000, 4'b0001, 32'hCAFE_0000, 1'b0, 3, 1);
        // 3: unmapped slot 5
        do_txn(32'h0350_0000, 4'b0000, 32'h0, -1, 32'h0, 4'b0000, ERR, 1'b1, 2, 0);
        // 4: slot 2 never answers -> timeout
        do_txn(32'h0320_0000, 4'b0000, 32'h0, -1, 32'h0, 4'b0100, ERR, 1'b1, TO + 2, TO);
        // 4b: s_ready at the expiry cycle wins
        do_txn(32'h0320_0008, 4'b0000, 32'h0, TO - 1, 32'h0BAD_F00D, 4'b0100, 32'h0BAD_F00D, 1'b0, TO + 2, TO);

        // 5: foreign address is ignored
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h0200_0000;
        seen_ready = 0;
        seen_sv    = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_ready) seen_ready++;
            if (s_valid != '0) seen_sv++;
        end
        m_valid = 1'b0;
        check("ignored_ready", 64'(seen_ready), 64'd0);
        check("ignored_s_valid", 64'(seen_sv), 64'd0);

        // 5b: reset in the middle of BUSY aborts the access without an ack
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h0320_0000;
        repeat (3) @(negedge clk);
        check("busy_before_reset", 64'(s_valid), 64'b0100);
        resetn  = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_s_valid", 64'(s_valid), 64'd0);
        check("mid_rst_m_ready", 64'(m_ready), 64'd0);
        check("mid_rst_err_count", 64'(err_count), 64'd0);
        check("mid_rst_err_addr", 64'(err_addr), 64'd0);
        mdl_ecnt  = 8'd0;
        mdl_eaddr = 32'd0;
        resetn = 1'b1;
        // After the abort, the block must be back in IDLE and accept a normal access.
        do_txn(32'h0310_0020, 4'b0000, 32'h0, 0, 32'h7777_0001, 4'b0010, 32'h7777_0001, 1'b0, 3, 1);

        // 6: 300 unmapped accesses -> err_count saturates at 255
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {8'h03, 4'(4 + (i % 12)), 20'(i)};
            do_txn(a, 4'b0000, 32'h0, -1, 32'h0, 4'b0000, ERR, 1'b1, 2, 0);
        end
        @(negedge clk);
        check("err_count_saturated", 64'(err_count), 64'd255);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
